// File: rtl/asic_pkg.sv
// Shared ACID/ASIC unlock definitions: the unlock byte table, port address and
// sender state encoding, imported by both ends of the unlock protocol.
package asic_pkg;

  localparam int unsigned SEQ_LEN = 17;

  localparam logic [7:0] UNLOCK_SEQ [0:16] = '{
    8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62, 8'h39,
    8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD, 8'hEE, 8'hFF,
    8'hFF
  };

  localparam logic [7:0]  RELOCK_BYTE = 8'h00;
  localparam logic [15:0] ACID_PORT   = 16'hBC00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_STROBE,
    ST_GAP,
    ST_FINISH,
    ST_ABORT
  } sender_state_e;

  // The relock variant differs only in the final byte.
  function automatic logic [7:0] seq_byte(input logic [4:0] idx, input logic relock);
    if (relock && idx == 5'd16) return RELOCK_BYTE;
    return UNLOCK_SEQ[idx];
  endfunction

endpackage

// File: rtl/asic_unlock_sender.sv
// Bus-master sequencer writing the 17-byte ASIC unlock (or relock) sequence to
// the CRTC select port. All outputs are registered from the next-state values.
module asic_unlock_sender
  import asic_pkg::*;
#(
  parameter logic [15:0] PORT_ADDR   = ACID_PORT,
  parameter int unsigned WR_CYCLES   = 2,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned GNT_TIMEOUT = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        plus_mode,
  input  logic        start,
  input  logic        relock,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] io_addr,
  output logic [7:0]  io_dout,
  output logic        io_wr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [4:0]  byte_index
);

  localparam int unsigned WAIT_W = $clog2(GNT_TIMEOUT);
  localparam int unsigned PH_MAX = (WR_CYCLES > GAP_CYCLES) ? WR_CYCLES : GAP_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GNT_TIMEOUT - 1);
  localparam logic [PH_W-1:0]   WR_LAST   = PH_W'(WR_CYCLES - 1);
  localparam logic [PH_W-1:0]   GAP_LAST  = PH_W'(GAP_CYCLES - 1);
  localparam logic [4:0]        LAST_IDX  = 5'(SEQ_LEN - 1);

  sender_state_e     state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [4:0]        idx_q, idx_d;
  logic              relock_q, relock_d;
  logic              bus_req_q, bus_req_d;
  logic              io_wr_q, io_wr_d;
  logic [15:0]       io_addr_q, io_addr_d;
  logic [7:0]        io_dout_q, io_dout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      phase_q   <= '0;
      idx_q     <= '0;
      relock_q  <= 1'b0;
      bus_req_q <= 1'b0;
      io_wr_q   <= 1'b0;
      io_addr_q <= '0;
      io_dout_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      relock_q  <= relock_d;
      bus_req_q <= bus_req_d;
      io_wr_q   <= io_wr_d;
      io_addr_q <= io_addr_d;
      io_dout_q <= io_dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    relock_d  = relock_q;
    io_addr_d = io_addr_q;
    io_dout_d = io_dout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && plus_mode) begin
          relock_d = relock;
          idx_d    = '0;
          wait_d   = '0;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!plus_mode) begin
          state_d = ST_ABORT;
        end else if (bus_gnt) begin
          phase_d = '0;
          state_d = ST_STROBE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_ABORT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_STROBE: begin
        if (!plus_mode || !bus_gnt) begin
          state_d = ST_ABORT;
        end else if (phase_q == WR_LAST) begin
          phase_d = '0;
          state_d = (idx_q == LAST_IDX) ? ST_FINISH : ST_GAP;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (!plus_mode) begin
          state_d = ST_ABORT;
        end else if (phase_q == GAP_LAST) begin
          phase_d = '0;
          wait_d  = '0;
          idx_d   = idx_q + 1'b1;
          state_d = bus_gnt ? ST_STROBE : ST_REQ;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ABORT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Address/data are loaded once on strobe entry so they stay stable through
    // the strobe and the following gap.
    if (state_d == ST_STROBE && state_q != ST_STROBE) begin
      io_addr_d = PORT_ADDR;
      io_dout_d = seq_byte(idx_d, relock_q);
    end

    bus_req_d = (state_d == ST_REQ) || (state_d == ST_STROBE) ||
                (state_d == ST_GAP) || (state_d == ST_FINISH);
    io_wr_d   = (state_d == ST_STROBE);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_FINISH);
    error_d   = (state_d == ST_ABORT);
  end

  assign bus_req    = bus_req_q;
  assign io_wr      = io_wr_q;
  assign io_addr    = io_addr_q;
  assign io_dout    = io_dout_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign byte_index = idx_q;

endmodule

// File: tb/tb_asic_unlock_sender.sv
// Directed bench for asic_unlock_sender: cycle-indexed stimulus schedules with
// hand-computed strobe timing and data checked against an independent byte table.
module tb_asic_unlock_sender;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        plus_mode = 1'b1;
  logic        start = 1'b0;
  logic        relock = 1'b0;
  logic        bus_gnt = 1'b1;
  logic        bus_req;
  logic [15:0] io_addr;
  logic [7:0]  io_dout;
  logic        io_wr;
  logic        busy;
  logic        done;
  logic        error;
  logic [4:0]  byte_index;

  asic_unlock_sender #(
    .PORT_ADDR   (16'hBC00),
    .WR_CYCLES   (2),
    .GAP_CYCLES  (4),
    .GNT_TIMEOUT (16)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .plus_mode  (plus_mode),
    .start      (start),
    .relock     (relock),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .io_addr    (io_addr),
    .io_dout    (io_dout),
    .io_wr      (io_wr),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .byte_index (byte_index)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] exp_seq [0:16] = '{
    8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62, 8'h39,
    8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD, 8'hEE, 8'hFF, 8'hFF
  };

  int n_cmp = 0;
  int n_bad = 0;

  int         cyc;
  logic [7:0] wr_bytes [$];
  int         wr_start [$];
  int         wr_len   [$];
  int         cur_len;
  logic [7:0] cur_dout;
  logic       wr_prev = 1'b0;
  int         unstable;
  int         done_cyc, err_cyc, done_count;

  int gnt_lo, gnt_hi, plus_drop, restart_cyc, reset_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    if (io_wr) begin
      if (!wr_prev) begin
        wr_bytes.push_back(io_dout);
        wr_start.push_back(cyc);
        cur_dout = io_dout;
        cur_len  = 0;
        if (io_addr != 16'hBC00) unstable++;
      end else if (io_dout != cur_dout || io_addr != 16'hBC00) begin
        unstable++;
      end
      cur_len++;
    end else if (wr_prev) begin
      wr_len.push_back(cur_len);
    end
    wr_prev = io_wr;
    if (done) done_count++;
    if (done && done_cyc < 0) done_cyc = cyc;
    if (error && err_cyc < 0) err_cyc = cyc;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    cyc++;
    sample();
  endtask

  task automatic apply();
    start     = (cyc == 0) || (cyc == restart_cyc);
    bus_gnt   = !(cyc >= gnt_lo && cyc <= gnt_hi);
    plus_mode = !(plus_drop >= 0 && cyc >= plus_drop);
    reset     = (cyc == reset_cyc);
  endtask

  task automatic set_sched(input int lo, input int hi, input int pdrop, input int rst, input int rcyc);
    gnt_lo = lo; gnt_hi = hi; plus_drop = pdrop; restart_cyc = rst; reset_cyc = rcyc;
  endtask

  task automatic idle(input int n);
    start = 1'b0; bus_gnt = 1'b1; plus_mode = 1'b1; reset = 1'b0;
    repeat (n) tick();
  endtask

  // Cycle 0 is the cycle in which start is presented; runs stop on done, error or the limit.
  task automatic run_seq(input string name, input logic rl, input int limit);
    wr_bytes.delete(); wr_start.delete(); wr_len.delete();
    done_cyc = -1; err_cyc = -1; done_count = 0; unstable = 0;
    relock = rl;
    cyc = 0;
    apply();
    while (cyc < limit && done_cyc < 0 && err_cyc < 0) begin
      tick();
      apply();
    end
    $display("run %s: writes=%0d first_wr=%0d done_cyc=%0d err_cyc=%0d byte_index=%0d",
             name, wr_bytes.size(), (wr_start.size() > 0) ? wr_start[0] : -1,
             done_cyc, err_cyc, byte_index);
  endtask

  task automatic check_full(input string tag, input logic rl, input int exp_done);
    logic [7:0] eb;
    check_eq({tag, "_nwr"}, wr_bytes.size(), 17);
    check_eq({tag, "_done_cyc"}, done_cyc, exp_done);
    check_eq({tag, "_no_err"}, err_cyc, -1);
    check_eq({tag, "_stable"}, unstable, 0);
    for (int i = 0; i < wr_bytes.size(); i++) begin
      eb = (rl && i == 16) ? 8'h00 : exp_seq[i];
      check_eq($sformatf("%s_byte%0d", tag, i), wr_bytes[i], eb);
    end
    for (int i = 0; i < wr_len.size(); i++)
      check_eq($sformatf("%s_len%0d", tag, i), wr_len[i], 2);
  endtask

  initial begin
    set_sched(-1, -1, -1, -1, -1);
    cyc = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    tick();
    check_eq("rst_bus_req", bus_req, 0);
    check_eq("rst_io_wr", io_wr, 0);
    check_eq("rst_io_addr", io_addr, 16'h0000);
    check_eq("rst_io_dout", io_dout, 8'h00);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done_err", {done, error}, 2'b00);
    check_eq("rst_byte_index", byte_index, 0);

    // start with plus_mode low is silently ignored
    start = 1'b1; plus_mode = 1'b0;
    tick();
    start = 1'b0; plus_mode = 1'b1;
    tick();
    check_eq("noplus_busy", busy, 0);
    check_eq("noplus_err", error, 0);
    idle(2);

    // 1: nominal unlock
    set_sched(-1, -1, -1, -1, -1);
    run_seq("nominal", 1'b0, 200);
    check_full("nom", 1'b0, 100);
    check_eq("nom_first_wr", (wr_start.size() > 0) ? wr_start[0] : -1, 2);
    idle(1);
    check_eq("nom_after_bus_req", bus_req, 0);
    check_eq("nom_after_busy", busy, 0);
    idle(2);

    // 2: relock variant
    run_seq("relock", 1'b1, 200);
    check_full("rlk", 1'b1, 100);
    idle(3);

    // 3a: grant withheld for cycles 0..10
    set_sched(0, 10, -1, -1, -1);
    run_seq("gnt_delay", 1'b0, 250);
    check_eq("dly_first_wr", (wr_start.size() > 0) ? wr_start[0] : -1, 12);
    check_eq("dly_done_cyc", done_cyc, 110);
    check_eq("dly_nwr", wr_bytes.size(), 17);
    idle(3);

    // 3b: grant drops during the gap after byte 5, back at cycle 38
    set_sched(35, 37, -1, -1, -1);
    run_seq("gnt_gap", 1'b0, 250);
    check_full("gap", 1'b0, 101);
    check_eq("gap_byte6_start", (wr_start.size() > 6) ? wr_start[6] : -1, 39);
    idle(3);

    // 4: grant never arrives
    set_sched(0, 1000, -1, -1, -1);
    run_seq("timeout", 1'b0, 60);
    check_eq("to_err_cyc", err_cyc, 17);
    check_eq("to_nwr", wr_bytes.size(), 0);
    check_eq("to_bus_req", bus_req, 0);
    idle(1);
    check_eq("to_after_busy", busy, 0);
    check_eq("to_after_err", error, 0);
    idle(2);

    // 5a: plus_mode drops in the first cycle of byte 8's strobe
    set_sched(-1, -1, 50, -1, -1);
    run_seq("plus_drop", 1'b0, 200);
    check_eq("pd_err_cyc", err_cyc, 51);
    check_eq("pd_io_wr", io_wr, 0);
    check_eq("pd_byte_index", byte_index, 8);
    check_eq("pd_bus_req", bus_req, 0);
    check_eq("pd_nwr", wr_bytes.size(), 9);
    idle(3);

    // 5b: grant drops in the second cycle of byte 2's strobe
    set_sched(15, 15, -1, -1, -1);
    run_seq("gnt_strobe", 1'b0, 200);
    check_eq("gs_err_cyc", err_cyc, 16);
    check_eq("gs_byte_index", byte_index, 2);
    idle(3);

    // 6a: start re-pulsed while busy
    set_sched(-1, -1, -1, 40, -1);
    run_seq("restart", 1'b0, 200);
    check_full("rs", 1'b0, 100);
    idle(5);
    check_eq("rs_total_wr", wr_bytes.size(), 17);
    check_eq("rs_done_count", done_count, 1);
    check_eq("rs_after_busy", busy, 0);
    idle(2);

    // 6b: reset asserted during byte 3's strobe
    set_sched(-1, -1, -1, -1, 20);
    run_seq("reset_mid", 1'b0, 21);
    check_eq("mr_io_wr", io_wr, 0);
    check_eq("mr_bus_req", bus_req, 0);
    check_eq("mr_io_addr", io_addr, 16'h0000);
    check_eq("mr_io_dout", io_dout, 8'h00);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_byte_index", byte_index, 0);
    check_eq("mr_nwr", wr_bytes.size(), 4);
    idle(2);
    check_eq("mr_idle_busy", busy, 0);

    set_sched(-1, -1, -1, -1, -1);
    run_seq("fresh", 1'b0, 200);
    check_full("fr", 1'b0, 100);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/asic_unlock_sender.md
Name: asic_unlock_sender

Overview:
- Bus-master sequencer that issues the 17-byte ASIC unlock sequence as I/O writes to the CRTC select port (&BCxx). It is the transmit side of the ACID unlock protocol.
- Used by the boot/auto-unlock path and by the debug menu. The Plus ASIC can be unlocked, or relocked, without Z80 software.
- Sits beside the Z80 on the I/O bus. It requests the bus through the existing arbiter and drives address, data and write strobe.

Parameters:
PORT_ADDR, 16'hBC00, I/O address driven for every write
WR_CYCLES, 2, io_wr high time per byte in clk_sys cycles (>=1)
GAP_CYCLES, 4, idle cycles between consecutive writes (>=1)
GNT_TIMEOUT, 1024, max cycles waiting for bus_gnt before abort (>=2)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
plus_mode  in  1  Plus mode enable; low = block inert, aborts any run
start  in  1  request a sequence; sampled only in IDLE
relock  in  1  sampled with start; 1 = replace byte 16 with 8'h00 (relock variant)
bus_req  out  1  bus request to arbiter
bus_gnt  in  1  bus grant from arbiter
io_addr  out  16  I/O address
io_dout  out  8  I/O write data
io_wr  out  1  I/O write strobe
busy  out  1  high from the cycle after accepted start until return to IDLE
done  out  1  one-cycle pulse: all 17 bytes written
error  out  1  one-cycle pulse: run aborted (timeout, grant loss, plus_mode drop)
byte_index  out  5  index of the byte currently being sent (0..16)

Behaviour:
- Reset: state=IDLE. bus_req=0, io_wr=0, io_addr=16'h0000, io_dout=8'h00, busy=0, done=0, error=0, byte_index=0. Counters and relock latch cleared.
- Reset mid-run takes effect the next cycle: all outputs return to reset values and no partial strobe continues.
- Sequence table: UNLOCK_SEQ[0..16] = FF 77 B3 51 A8 D4 62 39 9C 46 2B 15 8A CD EE FF FF. In relock mode byte 16 = 00.
- All outputs are registered.
- IDLE: if start && plus_mode, latch relock, byte_index<=0, go to REQ. start while not in IDLE is ignored. start with plus_mode=0 is ignored with no error.
- REQ: bus_req=1, busy=1, wait counter increments.
  - bus_gnt=1: go to STROBE next cycle.
  - Counter reaches GNT_TIMEOUT-1 without grant: go to ABORT.
- STROBE: io_addr=PORT_ADDR, io_dout=seq[byte_index], io_wr=1 for exactly WR_CYCLES cycles.
  - Address and data are stable for the whole strobe.
  - bus_gnt low during STROBE: go to ABORT.
  - At strobe end, byte 16 goes to FINISH; otherwise go to GAP.
- GAP: io_wr=0, io_addr/io_dout held, bus_req stays 1, GAP_CYCLES cycles, byte_index increments on GAP exit.
  - Exit to STROBE if bus_gnt=1, else to REQ; the REQ timeout counter restarts.
- FINISH: one cycle. done=1, bus_req=0, busy=0 in the following IDLE.
- ABORT: one cycle. error=1, bus_req=0, io_wr=0, then IDLE. byte_index holds the failing index for that cycle.
- plus_mode falling in any non-IDLE state goes to ABORT next cycle. io_wr drops immediately in that cycle.
- Latency, grant already high: start at cycle 0, REQ at cycle 1, first io_wr high at cycle 2.
- Total run with constant grant: 2 + 17*WR_CYCLES + 16*GAP_CYCLES cycles to the done pulse. Defaults give 2+34+64=100.
- Wait counter width: $clog2(GNT_TIMEOUT). Strobe and gap counters sized for max(WR_CYCLES, GAP_CYCLES). No wrap is possible within a state.

Decomposition:
- Shared package asic_pkg holds:
  - UNLOCK_SEQ[0:16] localparam array.
  - RELOCK_BYTE=8'h00 and ACID_PORT=16'hBC00.
  - sender state typedef (IDLE, REQ, STROBE, GAP, FINISH, ABORT).
- The ACID detector imports the same UNLOCK_SEQ so the two ends cannot diverge.
- Single module, no sub-module. Table lookup and counters are inline.

Test Plan:
1. Nominal: bus_gnt tied 1, start pulse, plus_mode=1, relock=0 -> 17 io_wr pulses of 2 cycles at addr BC00, data FF,77,B3,...,CD,EE,FF,FF. done pulse at cycle 100; bus_req low afterwards. A connected ACID detector reports asic_valid=1.
2. Relock: same with relock=1 -> byte 16 written as 00, bytes 0-15 unchanged, done at cycle 100.
3. Grant delay/loss:
   - bus_gnt low for 10 cycles after start -> first strobe at cycle 12.
   - bus_gnt dropped during GAP after byte 5 and restored 3 cycles later -> byte 6 strobes once grant returns; sequence completes.
4. Timeout: bus_gnt held 0, GNT_TIMEOUT=16 -> error pulse 16 cycles after REQ entry, no io_wr ever, bus_req low, busy low next cycle.
5. Abort paths:
   - plus_mode dropped during byte 8 strobe -> io_wr low next cycle, error pulse, byte_index=8 in the abort cycle.
   - bus_gnt dropped mid-strobe -> error pulse.
6. Start and reset:
   - start re-pulsed during busy -> ignored; exactly 17 writes occur.
   - Synchronous reset at byte 3 -> all outputs at reset values next cycle.
   - Fresh start afterwards -> a full clean sequence.
